// File: rtl/phy_rx_pkg.sv
// Shared types and defaults for the PHY receive deserialiser / word aligner.
//   lane_state_e     : per-lane alignment state (HUNT, ALIGN, LOCKED)
//   COMMA_DEFAULT    : default alignment / idle symbol
//   LOCK_CNT_DEFAULT : default number of consecutive commas needed for lock
package phy_rx_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'b00,
      ALIGN  = 2'b01,
      LOCKED = 2'b10
   } lane_state_e;

   localparam logic [7:0] COMMA_DEFAULT    = 8'hBC;
   localparam int         LOCK_CNT_DEFAULT = 4;

endpackage

// File: rtl/phy_rx_lane_align.sv
// One receive lane: serial-to-parallel shift register, bit/comma counters,
// comma hunt/align/lock FSM and registered word outputs.
//   clk_8f     in  : bit clock, rising edge
//   reset      in  : asynchronous, active-low
//   data_in    in  : serial bit, MSB of each word first
//   relock     in  : synchronous request to drop lock and re-hunt
//   data_out   out : last word captured while locked (held between strobes)
//   valid_out  out : captured word is data, not a comma
//   word_stb   out : one-cycle pulse when data_out/valid_out update
//   locked     out : lane is in LOCKED state
//   locked_nxt out : combinational next value of locked (for the lane-AND)
module phy_rx_lane_align
   import phy_rx_pkg::*;
#(
   parameter int             W        = 8,
   parameter logic [W-1:0]   COMMA    = W'(COMMA_DEFAULT),
   parameter int             LOCK_CNT = LOCK_CNT_DEFAULT
) (
   input  logic         clk_8f,
   input  logic         reset,
   input  logic         data_in,
   input  logic         relock,
   output logic [W-1:0] data_out,
   output logic         valid_out,
   output logic         word_stb,
   output logic         locked,
   output logic         locked_nxt
);

   localparam int BW = $clog2(W);
   localparam int CW = $clog2(LOCK_CNT + 1);

   localparam logic [BW-1:0] BIT_ZERO = {BW{1'b0}};
   localparam logic [BW-1:0] BIT_ONE  = BW'(32'd1);
   localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
   localparam logic [CW-1:0] CNT_LOCK = CW'(LOCK_CNT);

   // The oldest bit of the W-bit window is never read again once the next
   // bit arrives, so only W-1 history bits are stored.
   logic [W-2:0]  sr_r;
   logic [BW-1:0] bit_cnt_r;
   logic [CW-1:0] comma_cnt_r;
   lane_state_e   state_r;
   logic [W-1:0]  data_r;
   logic          valid_r;
   logic          stb_r;
   logic          locked_r;

   logic [W-1:0]  nxt_s;
   logic          word_done_s;
   logic          is_comma_s;
   logic [CW-1:0] cnt_inc_s;
   lane_state_e   state_nxt_s;
   logic [BW-1:0] bit_cnt_nxt_s;
   logic [CW-1:0] comma_cnt_nxt_s;
   logic [W-1:0]  data_nxt_s;
   logic          valid_nxt_s;
   logic          stb_nxt_s;

   assign nxt_s       = {sr_r, data_in};
   assign word_done_s = (bit_cnt_r == BIT_LAST);
   assign is_comma_s  = (nxt_s == COMMA);
   assign cnt_inc_s   = comma_cnt_r + CNT_ONE;

   // Next-state and output-register logic for the hunt/align/lock FSM.
   always_comb begin
      state_nxt_s     = state_r;
      bit_cnt_nxt_s   = word_done_s ? BIT_ZERO : (bit_cnt_r + BIT_ONE);
      comma_cnt_nxt_s = comma_cnt_r;
      data_nxt_s      = data_r;
      valid_nxt_s     = valid_r;
      stb_nxt_s       = 1'b0;

      if (relock) begin
         // Relock wins over any word completing this cycle; data_out holds.
         state_nxt_s     = HUNT;
         bit_cnt_nxt_s   = BIT_ZERO;
         comma_cnt_nxt_s = CNT_ZERO;
         valid_nxt_s     = 1'b0;
      end else begin
         case (state_r)
            HUNT: begin
               // Sliding-window search: the comma may end on any bit.
               if (is_comma_s) begin
                  bit_cnt_nxt_s   = BIT_ZERO;
                  comma_cnt_nxt_s = CNT_ONE;
                  state_nxt_s     = (LOCK_CNT == 1) ? LOCKED : ALIGN;
               end else begin
                  state_nxt_s = HUNT;
               end
            end
            ALIGN: begin
               if (word_done_s) begin
                  if (is_comma_s) begin
                     comma_cnt_nxt_s = cnt_inc_s;
                     state_nxt_s     = (cnt_inc_s == CNT_LOCK) ? LOCKED : ALIGN;
                  end else begin
                     comma_cnt_nxt_s = CNT_ZERO;
                     state_nxt_s     = HUNT;
                  end
               end else begin
                  state_nxt_s = ALIGN;
               end
            end
            LOCKED: begin
               // Word boundary is frozen; a straddling comma is just data.
               if (word_done_s) begin
                  data_nxt_s  = nxt_s;
                  valid_nxt_s = !is_comma_s;
                  stb_nxt_s   = 1'b1;
               end else begin
                  state_nxt_s = LOCKED;
               end
            end
            default: begin
               state_nxt_s     = HUNT;
               bit_cnt_nxt_s   = BIT_ZERO;
               comma_cnt_nxt_s = CNT_ZERO;
               valid_nxt_s     = 1'b0;
            end
         endcase
      end
   end

   assign locked_nxt = (state_nxt_s == LOCKED);

   // Lane state, counters, shift register and registered outputs.
   always_ff @(posedge clk_8f or negedge reset) begin
      if (!reset) begin
         sr_r        <= {(W-1){1'b0}};
         bit_cnt_r   <= BIT_ZERO;
         comma_cnt_r <= CNT_ZERO;
         state_r     <= HUNT;
         data_r      <= {W{1'b0}};
         valid_r     <= 1'b0;
         stb_r       <= 1'b0;
         locked_r    <= 1'b0;
      end else begin
         sr_r        <= nxt_s[W-2:0];
         bit_cnt_r   <= bit_cnt_nxt_s;
         comma_cnt_r <= comma_cnt_nxt_s;
         state_r     <= state_nxt_s;
         data_r      <= data_nxt_s;
         valid_r     <= valid_nxt_s;
         stb_r       <= stb_nxt_s;
         locked_r    <= locked_nxt;
      end
   end

   assign data_out  = data_r;
   assign valid_out = valid_r;
   assign word_stb  = stb_r;
   assign locked    = locked_r;

endmodule

// File: rtl/phy_rx_deser_align.sv
// Multi-lane receive deserialiser with per-lane comma alignment.
//   clk_8f     in  : bit clock, rising edge
//   reset      in  : asynchronous, active-low
//   data_in    in  [LANES]   : serial bit per lane
//   relock     in  [LANES]   : per-lane re-hunt request
//   data_out   out [LANES*W] : lane i word at [i*W +: W]
//   valid_out  out [LANES]   : word is data (not comma)
//   word_stb   out [LANES]   : one-cycle word update pulse
//   locked     out [LANES]   : lane locked
//   all_locked out           : every lane locked (same cycle as locked)
module phy_rx_deser_align
   import phy_rx_pkg::*;
#(
   parameter int           LANES    = 2,
   parameter int           W        = 8,
   parameter logic [W-1:0] COMMA    = W'(COMMA_DEFAULT),
   parameter int           LOCK_CNT = LOCK_CNT_DEFAULT
) (
   input  logic               clk_8f,
   input  logic               reset,
   input  logic [LANES-1:0]   data_in,
   input  logic [LANES-1:0]   relock,
   output logic [LANES*W-1:0] data_out,
   output logic [LANES-1:0]   valid_out,
   output logic [LANES-1:0]   word_stb,
   output logic [LANES-1:0]   locked,
   output logic               all_locked
);

   logic [LANES-1:0] locked_nxt_s;
   logic             all_locked_r;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      phy_rx_lane_align #(
         .W        (W),
         .COMMA    (COMMA),
         .LOCK_CNT (LOCK_CNT)
      ) u_lane (
         .clk_8f     (clk_8f),
         .reset      (reset),
         .data_in    (data_in[i]),
         .relock     (relock[i]),
         .data_out   (data_out[i*W +: W]),
         .valid_out  (valid_out[i]),
         .word_stb   (word_stb[i]),
         .locked     (locked[i]),
         .locked_nxt (locked_nxt_s[i])
      );
   end

   // Registered from next-state lock so it rises with the last lane's locked.
   always_ff @(posedge clk_8f or negedge reset) begin
      if (!reset) begin
         all_locked_r <= 1'b0;
      end else begin
         all_locked_r <= &locked_nxt_s;
      end
   end

   assign all_locked = all_locked_r;

endmodule

// File: tb/tb_phy_rx_deser_align.sv
// Directed self-checking bench for phy_rx_deser_align: a default 2-lane
// instance and a 4-lane, 10-bit, LOCK_CNT=1 instance share one bit clock.
module tb_phy_rx_deser_align;

   logic clk_8f = 1'b0;
   always #5 clk_8f = ~clk_8f;

   logic        reset;
   logic [1:0]  data_in, relock;
   logic [15:0] data_out;
   logic [1:0]  valid_out, word_stb, locked;
   logic        all_locked;

   logic [3:0]  data_in_p, relock_p;
   logic [39:0] data_out_p;
   logic [3:0]  valid_out_p, word_stb_p, locked_p;
   logic        all_locked_p;

   int checks   = 0;
   int failures = 0;

   logic [1:0]  seq   [0:127];
   logic [3:0]  seqp  [0:127];
   logic [1:0]  tr_locked [0:127];
   logic [1:0]  tr_stb    [0:127];
   logic [1:0]  tr_valid  [0:127];
   logic [15:0] tr_data   [0:127];
   logic        tr_all    [0:127];
   logic [3:0]  trp_locked [0:127];
   logic [3:0]  trp_stb    [0:127];
   logic [3:0]  trp_valid  [0:127];
   logic [39:0] trp_data   [0:127];
   logic        trp_all    [0:127];

   phy_rx_deser_align dut (
      .clk_8f     (clk_8f),
      .reset      (reset),
      .data_in    (data_in),
      .relock     (relock),
      .data_out   (data_out),
      .valid_out  (valid_out),
      .word_stb   (word_stb),
      .locked     (locked),
      .all_locked (all_locked)
   );

   phy_rx_deser_align #(
      .LANES    (4),
      .W        (10),
      .COMMA    (10'h17C),
      .LOCK_CNT (1)
   ) dut_p (
      .clk_8f     (clk_8f),
      .reset      (reset),
      .data_in    (data_in_p),
      .relock     (relock_p),
      .data_out   (data_out_p),
      .valid_out  (valid_out_p),
      .word_stb   (word_stb_p),
      .locked     (locked_p),
      .all_locked (all_locked_p)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_seq();
      for (int i = 0; i < 128; i++) begin
         seq[i]  = 2'b00;
         seqp[i] = 4'b0000;
      end
   endtask

   // Place a word MSB first on one lane starting at bit slot 'start'.
   task automatic put_word(input int lane, input int start, input logic [15:0] w, input int width);
      for (int i = 0; i < width; i++) seq[start+i][lane] = w[width-1-i];
   endtask

   task automatic put_word_p(input int lane, input int start, input logic [15:0] w, input int width);
      for (int i = 0; i < width; i++) seqp[start+i][lane] = w[width-1-i];
   endtask

   // Tick k drives slot k-1 at the falling edge; outputs traced 1 after edge k.
   task automatic run(input int n, input int relock_tick);
      for (int k = 1; k <= n; k++) begin
         @(negedge clk_8f);
         data_in   = seq[k-1];
         data_in_p = seqp[k-1];
         relock    = (k == relock_tick) ? 2'b01 : 2'b00;
         @(posedge clk_8f);
         #1;
         tr_locked[k]  = locked;
         tr_stb[k]     = word_stb;
         tr_valid[k]   = valid_out;
         tr_data[k]    = data_out;
         tr_all[k]     = all_locked;
         trp_locked[k] = locked_p;
         trp_stb[k]    = word_stb_p;
         trp_valid[k]  = valid_out_p;
         trp_data[k]   = data_out_p;
         trp_all[k]    = all_locked_p;
      end
      relock = 2'b00;
   endtask

   task automatic rst_pulse();
      @(negedge clk_8f);
      reset     = 1'b0;
      data_in   = 2'b00;
      data_in_p = 4'b0000;
      relock    = 2'b00;
      @(negedge clk_8f);
      reset = 1'b1;
   endtask

   function automatic int count_stb(input int lane, input int from, input int to);
      int n = 0;
      for (int k = from; k <= to; k++) if (tr_stb[k][lane]) n++;
      return n;
   endfunction

   function automatic int count_stb_p(input int lane, input int from, input int to);
      int n = 0;
      for (int k = from; k <= to; k++) if (trp_stb[k][lane]) n++;
      return n;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset     = 1'b0;
      data_in   = 2'b00;
      relock    = 2'b00;
      data_in_p = 4'b0000;
      relock_p  = 4'b0000;

      // Reset held with toggling serial input.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_8f);
         data_in   = (i % 2 == 0) ? 2'b11 : 2'b00;
         data_in_p = (i % 2 == 0) ? 4'b1111 : 4'b0000;
         @(posedge clk_8f);
         #1;
         check("rst_data", {48'd0, data_out}, 64'd0);
         check("rst_valid", {62'd0, valid_out}, 64'd0);
         check("rst_stb", {62'd0, word_stb}, 64'd0);
         check("rst_locked", {62'd0, locked}, 64'd0);
         check("rst_all", {63'd0, all_locked}, 64'd0);
         check("rst_p_data", {24'd0, data_out_p}, 64'd0);
         check("rst_p_locked", {60'd0, locked_p}, 64'd0);
      end
      @(negedge clk_8f);
      reset   = 1'b1;
      data_in = 2'b00;

      // Basic lock on lane 0: BC x4, A5, 5A.
      clear_seq();
      put_word(0, 0, 16'hBC, 8);
      put_word(0, 8, 16'hBC, 8);
      put_word(0, 16, 16'hBC, 8);
      put_word(0, 24, 16'hBC, 8);
      put_word(0, 32, 16'hA5, 8);
      put_word(0, 40, 16'h5A, 8);
      run(48, 0);
      check("basic_lock_pre", {63'd0, tr_locked[31][0]}, 64'd0);
      check("basic_lock_at", {63'd0, tr_locked[32][0]}, 64'd1);
      check("basic_no_early_stb", count_stb(0, 1, 39), 64'd0);
      check("basic_stb1", {63'd0, tr_stb[40][0]}, 64'd1);
      check("basic_data1", {56'd0, tr_data[40][7:0]}, 64'hA5);
      check("basic_valid1", {63'd0, tr_valid[40][0]}, 64'd1);
      check("basic_period", count_stb(0, 41, 47), 64'd0);
      check("basic_stb2", {63'd0, tr_stb[48][0]}, 64'd1);
      check("basic_data2", {56'd0, tr_data[48][7:0]}, 64'h5A);
      check("basic_lane1_idle", {63'd0, tr_locked[48][1]}, 64'd0);
      check("basic_all", {63'd0, tr_all[48]}, 64'd0);

      // Offset hunt: 3 junk bits, BC x4, 3C, BC.
      rst_pulse();
      clear_seq();
      put_word(0, 0, 16'h0006, 3);
      put_word(0, 3, 16'hBC, 8);
      put_word(0, 11, 16'hBC, 8);
      put_word(0, 19, 16'hBC, 8);
      put_word(0, 27, 16'hBC, 8);
      put_word(0, 35, 16'h3C, 8);
      put_word(0, 43, 16'hBC, 8);
      run(51, 0);
      check("ofs_lock_pre", {63'd0, tr_locked[34][0]}, 64'd0);
      check("ofs_lock_at", {63'd0, tr_locked[35][0]}, 64'd1);
      check("ofs_stb1", {63'd0, tr_stb[43][0]}, 64'd1);
      check("ofs_data1", {56'd0, tr_data[43][7:0]}, 64'h3C);
      check("ofs_valid1", {63'd0, tr_valid[43][0]}, 64'd1);
      check("ofs_stb_count", count_stb(0, 36, 50), 64'd1);
      check("ofs_stb2", {63'd0, tr_stb[51][0]}, 64'd1);
      check("ofs_data2", {56'd0, tr_data[51][7:0]}, 64'hBC);
      check("ofs_valid2_comma", {63'd0, tr_valid[51][0]}, 64'd0);

      // Broken alignment: BC, BC, 12, BC x4, 55.
      rst_pulse();
      clear_seq();
      put_word(0, 0, 16'hBC, 8);
      put_word(0, 8, 16'hBC, 8);
      put_word(0, 16, 16'h12, 8);
      put_word(0, 24, 16'hBC, 8);
      put_word(0, 32, 16'hBC, 8);
      put_word(0, 40, 16'hBC, 8);
      put_word(0, 48, 16'hBC, 8);
      put_word(0, 56, 16'h55, 8);
      run(64, 0);
      check("brk_no_lock_32", {63'd0, tr_locked[32][0]}, 64'd0);
      check("brk_lock_pre", {63'd0, tr_locked[55][0]}, 64'd0);
      check("brk_lock_at", {63'd0, tr_locked[56][0]}, 64'd1);
      check("brk_no_early_stb", count_stb(0, 1, 63), 64'd0);
      check("brk_stb", {63'd0, tr_stb[64][0]}, 64'd1);
      check("brk_data", {56'd0, tr_data[64][7:0]}, 64'h55);
      check("brk_valid", {63'd0, tr_valid[64][0]}, 64'd1);

      // Independent lanes, lane 1 five bits behind lane 0.
      rst_pulse();
      clear_seq();
      for (int j = 0; j < 4; j++) begin
         put_word(0, j*8, 16'hBC, 8);
         put_word(1, 5 + j*8, 16'hBC, 8);
      end
      put_word(0, 32, 16'hA5, 8);
      put_word(1, 37, 16'hC3, 8);
      run(45, 0);
      check("ind_locked_31", {62'd0, tr_locked[31]}, 64'd0);
      check("ind_locked_32", {62'd0, tr_locked[32]}, 64'd1);
      check("ind_locked_36", {62'd0, tr_locked[36]}, 64'd1);
      check("ind_locked_37", {62'd0, tr_locked[37]}, 64'd3);
      check("ind_all_36", {63'd0, tr_all[36]}, 64'd0);
      check("ind_all_37", {63'd0, tr_all[37]}, 64'd1);
      check("ind_l0_data", {56'd0, tr_data[40][7:0]}, 64'hA5);
      check("ind_l1_stb", {63'd0, tr_stb[45][1]}, 64'd1);
      check("ind_l1_data", {56'd0, tr_data[45][15:8]}, 64'hC3);
      check("ind_l1_valid", {63'd0, tr_valid[45][1]}, 64'd1);

      // Relock at bit 3 of a locked word, then relock on a fresh BC x4.
      rst_pulse();
      clear_seq();
      for (int j = 0; j < 4; j++) put_word(0, j*8, 16'hBC, 8);
      put_word(0, 32, 16'h77, 8);
      put_word(0, 40, 16'h99, 8);
      for (int j = 0; j < 4; j++) put_word(0, 48 + j*8, 16'hBC, 8);
      put_word(0, 80, 16'h5A, 8);
      run(92, 44);
      check("rlk_stb_77", {63'd0, tr_stb[40][0]}, 64'd1);
      check("rlk_lock_43", {63'd0, tr_locked[43][0]}, 64'd1);
      check("rlk_lock_44", {63'd0, tr_locked[44][0]}, 64'd0);
      check("rlk_data_held", {56'd0, tr_data[44][7:0]}, 64'h77);
      check("rlk_valid_low", {63'd0, tr_valid[44][0]}, 64'd0);
      check("rlk_no_stb", count_stb(0, 41, 87), 64'd0);
      check("rlk_relock_79", {63'd0, tr_locked[79][0]}, 64'd0);
      check("rlk_relock_80", {63'd0, tr_locked[80][0]}, 64'd1);
      check("rlk_stb_5a", {63'd0, tr_stb[88][0]}, 64'd1);
      check("rlk_data_5a", {56'd0, tr_data[88][7:0]}, 64'h5A);
      check("rlk_pre_rst_data", {56'd0, tr_data[92][7:0]}, 64'h5A);

      // Asynchronous reset in the middle of a locked word.
      @(negedge clk_8f);
      reset = 1'b0;
      #1;
      check("mrst_data", {48'd0, data_out}, 64'd0);
      check("mrst_valid", {62'd0, valid_out}, 64'd0);
      check("mrst_stb", {62'd0, word_stb}, 64'd0);
      check("mrst_locked", {62'd0, locked}, 64'd0);
      check("mrst_all", {63'd0, all_locked}, 64'd0);
      @(negedge clk_8f);
      reset = 1'b1;

      // Parameter sweep instance: 10-bit comma 17C on lane 2, lock on first comma.
      rst_pulse();
      clear_seq();
      put_word_p(2, 0, 16'h017C, 10);
      put_word_p(2, 10, 16'h02A5, 10);
      put_word_p(2, 20, 16'h0155, 10);
      run(30, 0);
      check("par_lock_9", {60'd0, trp_locked[9]}, 64'd0);
      check("par_lock_10", {60'd0, trp_locked[10]}, 64'h4);
      check("par_all", {63'd0, trp_all[10]}, 64'd0);
      check("par_stb_count", count_stb_p(2, 11, 29), 64'd1);
      check("par_stb1", {63'd0, trp_stb[20][2]}, 64'd1);
      check("par_data1", {54'd0, trp_data[20][29:20]}, 64'h2A5);
      check("par_valid1", {63'd0, trp_valid[20][2]}, 64'd1);
      check("par_stb2", {63'd0, trp_stb[30][2]}, 64'd1);
      check("par_data2", {54'd0, trp_data[30][29:20]}, 64'h155);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
